vector_reduce_sum_10_serial: RTL and testbench



---
 rtl/vector_reduce_sum_10_serial.sv | 173 +++++++++++++++++
 tb/tb_vector_reduce_sum_10_serial.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_reduce_sum_10_serial.sv
// Serial ten-element reducer: captures S0..S9 on inReady, then folds one element per cycle
// into a guard-bit accumulator and presents the total on Sum with earlyOutReady/outReady.
module vector_reduce_sum_10_serial #(
  parameter int IN_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inReady,
  input  logic signed [IN_WIDTH-1:0] S0,
  input  logic signed [IN_WIDTH-1:0] S1,
  input  logic signed [IN_WIDTH-1:0] S2,
  input  logic signed [IN_WIDTH-1:0] S3,
  input  logic signed [IN_WIDTH-1:0] S4,
  input  logic signed [IN_WIDTH-1:0] S5,
  input  logic signed [IN_WIDTH-1:0] S6,
  input  logic signed [IN_WIDTH-1:0] S7,
  input  logic signed [IN_WIDTH-1:0] S8,
  input  logic signed [IN_WIDTH-1:0] S9,
  output logic                       outReady,
  output logic signed [IN_WIDTH+3:0] Sum,
  output logic                       earlyOutReady,
  output logic                       busy
);

  localparam int ACC_W = IN_WIDTH + 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [3:0]                 r_count;
  logic [3:0]                 w_count_nxt;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [ACC_W-1:0]    w_acc_nxt;
  logic signed [ACC_W-1:0]    w_acc_add;
  logic signed [ACC_W-1:0]    r_sum;
  logic                       r_out;
  logic                       r_early;
  logic                       r_busy;
  logic                       w_early_nxt;
  logic                       w_busy_nxt;
  logic                       w_capture;
  logic                       w_finish;
  logic signed [IN_WIDTH-1:0] r_bank [10];
  logic signed [IN_WIDTH-1:0] w_in   [10];
  logic signed [IN_WIDTH-1:0] w_elem;

  // Four guard bits cover ten full-scale addends, so plain sign extension never wraps.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
    return {{4{x[IN_WIDTH-1]}}, x};
  endfunction

  assign w_in[0] = S0;
  assign w_in[1] = S1;
  assign w_in[2] = S2;
  assign w_in[3] = S3;
  assign w_in[4] = S4;
  assign w_in[5] = S5;
  assign w_in[6] = S6;
  assign w_in[7] = S7;
  assign w_in[8] = S8;
  assign w_in[9] = S9;

  always_comb begin
    w_elem = r_bank[9];
    case (r_count)
      4'd0:    w_elem = r_bank[0];
      4'd1:    w_elem = r_bank[1];
      4'd2:    w_elem = r_bank[2];
      4'd3:    w_elem = r_bank[3];
      4'd4:    w_elem = r_bank[4];
      4'd5:    w_elem = r_bank[5];
      4'd6:    w_elem = r_bank[6];
      4'd7:    w_elem = r_bank[7];
      4'd8:    w_elem = r_bank[8];
      default: w_elem = r_bank[9];
    endcase
  end

  assign w_acc_add = r_acc + sext(w_elem);

  // Next-state logic; the finish edge also re-opens capture so vectors can run back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_early_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (inReady) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_ACC;
          w_count_nxt = 4'd0;
          w_acc_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_ACC: begin
        w_acc_nxt   = w_acc_add;
        w_count_nxt = r_count + 4'd1;
        w_early_nxt = (r_count == 4'd8);
        if (r_count == 4'd9) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_count_nxt = 4'd0;
          w_acc_nxt   = '0;
          w_busy_nxt  = 1'b0;
          if (inReady) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_ACC;
            w_busy_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = 4'd0;
        w_acc_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else if (enable) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 4'd0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_out   <= 1'b0;
      r_early <= 1'b0;
      r_busy  <= 1'b0;
    end else if (enable) begin
      r_count <= w_count_nxt;
      r_acc   <= w_acc_nxt;
      r_out   <= w_finish;
      r_early <= w_early_nxt;
      r_busy  <= w_busy_nxt;
      if (w_finish) begin
        r_sum <= w_acc_add;
      end
    end
  end

  // Bank is isolated from S0..S9 after capture; its contents do not matter out of reset.
  always_ff @(posedge clk) begin
    if (enable && w_capture) begin
      for (int i = 0; i < 10; i++) begin
        r_bank[i] <= w_in[i];
      end
    end
  end

  assign outReady      = r_out;
  assign earlyOutReady = r_early;
  assign busy          = r_busy;
  assign Sum           = r_sum;

endmodule

// File: tb/tb_vector_reduce_sum_10_serial.sv
// Scoreboard bench for vector_reduce_sum_10_serial: expected sums queued at capture,
// popped when outReady rises; per-edge handshake timing checked inline.
module tb_vector_reduce_sum_10_serial;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               inReady;
  logic signed [15:0] s [10];
  logic               outReady;
  logic signed [19:0] sum_o;
  logic               earlyOutReady;
  logic               busy;

  int     n_chk = 0;
  int     n_err = 0;
  longint sb[$];
  longint last_sum = 0;
  longint cur_exp  = 0;
  int     vec [10];
  bit     prev_out = 1'b0;

  vector_reduce_sum_10_serial #(.IN_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .inReady      (inReady),
    .S0           (s[0]),
    .S1           (s[1]),
    .S2           (s[2]),
    .S3           (s[3]),
    .S4           (s[4]),
    .S5           (s[5]),
    .S6           (s[6]),
    .S7           (s[7]),
    .S8           (s[8]),
    .S9           (s[9]),
    .outReady     (outReady),
    .Sum          (sum_o),
    .earlyOutReady(earlyOutReady),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive vec onto S and request capture; the bench's own sum goes to the scoreboard.
  task automatic load();
    longint t;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      s[i] = 16'(vec[i]);
      t += longint'(vec[i]);
    end
    cur_exp = t;
    sb.push_back(t);
    inReady = 1'b1;
  endtask

  task automatic step(input string nm, input int k, input bit b, input bit e, input bit o);
    tick();
    chk($sformatf("%s busy E%0d", nm, k), longint'(busy), longint'(b));
    chk($sformatf("%s early E%0d", nm, k), longint'(earlyOutReady), longint'(e));
    chk($sformatf("%s out E%0d", nm, k), longint'(outReady), longint'(o));
  endtask

  task automatic run_plain(input string nm, input bit scr);
    longint want;
    load();
    want = cur_exp;
    step(nm, 0, 1'b1, 1'b0, 1'b0);
    inReady = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (scr) begin
        for (int i = 0; i < 10; i++) s[i] = 16'($urandom);
      end
      step(nm, k, k < 10, k == 9, k == 10);
    end
    step(nm, 11, 1'b0, 1'b0, 1'b0);
    chk({nm, " sum hold"}, longint'(sum_o), want);
  endtask

  // Scoreboard consumer: one pop per outReady rising, so a stalled pulse counts once.
  always @(negedge clk) begin
    if (reset) begin
      if (outReady && !prev_out) begin
        if (sb.size() == 0) begin
          chk("unexpected outReady", 1, 0);
        end else begin
          longint e;
          e = sb.pop_front();
          chk("sum", longint'(sum_o), e);
          last_sum = e;
        end
      end
      prev_out = outReady;
    end else begin
      prev_out = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint held;
    reset   = 1'b0;
    enable  = 1'b1;
    inReady = 1'b0;
    for (int i = 0; i < 10; i++) s[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst Sum", longint'(sum_o), 0);
    chk("rst outReady", longint'(outReady), 0);
    chk("rst early", longint'(earlyOutReady), 0);
    chk("rst busy", longint'(busy), 0);
    reset = 1'b1;
    step("idle", 0, 1'b0, 1'b0, 1'b0);

    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_plain("seq", 1'b0);
    vec = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    run_plain("minneg", 1'b0);
    vec = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    run_plain("maxpos", 1'b0);
    vec = '{100, -100, 5, -5, 0, 7, -3, 1, -1, 9};
    run_plain("mixed", 1'b1);

    // Busy-time request dropped; request on the finish edge chains the next vector.
    vec = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    load();
    step("chain", 0, 1'b1, 1'b0, 1'b0);
    inReady = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if (k == 4) begin
        inReady = 1'b1;
        for (int i = 0; i < 10; i++) s[i] = 16'($urandom);
      end
      if (k == 10) begin
        vec = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        load();
      end
      if (k <= 10) step("chain", k, 1'b1 && (k < 10 || k == 10), k == 9, k == 10);
      else         step("chain", k, k < 20, k == 19, k == 20);
      inReady = 1'b0;
    end
    chk("chain sum", longint'(sum_o), 30);

    // Three stalled edges after E5 push every later event out by three.
    for (int i = 0; i < 10; i++) vec[i] = int'($urandom_range(0, 65535)) - 32768;
    held = last_sum;
    load();
    step("stall", 0, 1'b1, 1'b0, 1'b0);
    inReady = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      enable = !(c >= 6 && c <= 8);
      step("stall", c, c < 13, c == 12, c == 13);
      if (c >= 6 && c <= 8) chk($sformatf("stall frozen E%0d", c), longint'(sum_o), held);
    end
    enable = 1'b1;
    chk("stall sum", longint'(sum_o), cur_exp);

    // Asynchronous reset mid-reduction discards the vector in flight.
    for (int i = 0; i < 10; i++) vec[i] = int'($urandom_range(1, 1000));
    load();
    step("abort", 0, 1'b1, 1'b0, 1'b0);
    inReady = 1'b0;
    for (int k = 1; k <= 6; k++) step("abort", k, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async Sum", longint'(sum_o), 0);
    chk("async outReady", longint'(outReady), 0);
    chk("async early", longint'(earlyOutReady), 0);
    chk("async busy", longint'(busy), 0);
    sb.delete();
    last_sum = 0;
    @(negedge clk);
    reset = 1'b1;
    step("post", 0, 1'b0, 1'b0, 1'b0);
    chk("post Sum", longint'(sum_o), 0);
    vec = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    run_plain("twos", 1'b0);

    tick();
    chk("sb empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
